// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: W-bit a-b-bin computed one nibble per clock through a single 4-bit slice
module FourBitSubtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - {4'b0, bin};
endmodule

module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Diff,
  output logic                 Bout,
  output logic                 Zero,
  output logic                 Ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]    r_state;
  logic [W-1:0]  r_a, r_b, r_res, r_diff;
  logic [IW-1:0] r_idx;
  logic          r_borrow, r_bout, r_zero, r_ovf;
  logic [3:0]    w_d;
  logic          w_bo, w_last;
  logic [W-1:0]  w_res;
  FourBitSubtractor u_slice (
    .a    (r_a[4*r_idx +: 4]),
    .b    (r_b[4*r_idx +: 4]),
    .bin  (r_borrow),
    .diff (w_d),
    .bout (w_bo)
  );
  assign w_last = r_idx == IW'(NIBBLES - 1);
  // working result with the current nibble merged in, so the final value is available on the last edge
  always_comb begin
    w_res = r_res;
    w_res[4*r_idx +: 4] = w_d;
  end
  // handshake, nibble sequencing and atomic result update on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_a      <= a;
        r_b      <= b;
        r_borrow <= bin;
        r_idx    <= '0;
        r_state  <= S_RUN;
      end
    end else if (r_state == S_RUN) begin
      r_res    <= w_res;
      r_borrow <= w_bo;
      r_idx    <= w_last ? r_idx : r_idx + 1'b1;
      if (w_last) begin
        r_diff  <= w_res;
        r_bout  <= w_bo;
        r_zero  <= w_res == '0;
        r_ovf   <= (r_a[W-1] ^ r_b[W-1]) & (w_res[W-1] ^ r_a[W-1]);
        r_state <= S_DONE;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end
  assign ready = r_state == S_IDLE;
  assign busy  = r_state == S_RUN;
  assign done  = r_state == S_DONE;
  assign Diff  = r_diff;
  assign Bout  = r_bout;
  assign Zero  = r_zero;
  assign Ovf   = r_ovf;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: randomized and directed checks of the serial subtractor against an arithmetic model
module tb_nibble_serial_subtractor;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, bin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        ready, busy, done, Bout, Zero, Ovf;
  logic [15:0] Diff;
  int n_tests = 0, n_fail = 0;

  nibble_serial_subtractor #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Zero(Zero), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ovf, zero, bout, diff} from plain 17-bit arithmetic
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] r;
    logic        ov;
    r  = {1'b0, x} - {1'b0, y} - 17'(c);
    ov = (x[15] != y[15]) && (r[15] != x[15]);
    return {ov, r[15:0] == 16'h0, r[16], r[15:0]};
  endfunction

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c, input bit glitch);
    logic [18:0] e;
    logic [15:0] pre;
    int cyc, nb;
    e = model(x, y, c);
    @(negedge clk);
    chk("ready_before", ready, 1);
    pre = Diff;
    a = x; b = y; bin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    cyc = 1; nb = 0;
    while (!done && cyc < 20) begin
      if (busy) nb++;
      chk("ready_busy", ready & busy, 0);
      chk("diff_hold", Diff, pre);
      if (glitch && cyc == 2) begin
        start = 1'b1; a = 16'hFFFF; b = 16'h0000;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("done_cycle", cyc, 5);
    chk("busy_cycles", nb, 4);
    chk("done_busy", busy, 0);
    chk("diff", Diff, e[15:0]);
    chk("bout", Bout, e[16]);
    chk("zero", Zero, e[17]);
    chk("ovf", Ovf, e[18]);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("ready_after", ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_flags", {Bout, Zero, Ovf}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h1234, 16'h0234, 1'b0, 0);
    chk("plan_diff_1000", Diff, 16'h1000);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    chk("plan_diff_ffff", {Diff, Bout, Ovf}, {16'hFFFF, 1'b1, 1'b0});
    run_op(16'h0005, 16'h0004, 1'b1, 0);
    chk("plan_zero", {Diff, Zero, Bout}, {16'h0000, 1'b1, 1'b0});
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    chk("plan_ovf_pos", {Diff, Ovf, Bout}, {16'h7FFF, 1'b1, 1'b0});
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    chk("plan_ovf_neg", {Diff, Ovf, Bout}, {16'h8000, 1'b1, 1'b1});
    for (int i = 0; i < 20; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 0);
    run_op(16'h00FF, 16'h000F, 1'b0, 1);
    chk("plan_ignored_start", Diff, 16'h00F0);
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", Diff, 0);
    chk("midrst_flags", {Bout, Zero, Ovf}, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
    end
    rst_n = 1'b1;
    run_op(16'h0010, 16'h0001, 1'b0, 0);
    chk("plan_after_rst", Diff, 16'h000F);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
